// File: rtl/uart_pkg.sv
// Shared UART types and defaults: receiver FSM states, frame geometry and a 3-input majority vote.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for one asynchronous input; 2 cycles latency, reset value parameterized.
// No backpressure: passes the line level straight through.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with mid-bit majority vote; byte lands 2 cycles + ~9.5 bit times after start edge.
// No backpressure: rdy is held until rdy_clr, a byte arriving while rdy=1 overwrites data and flags overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 vote;
  logic [SW-1:0]        s_inc;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    samp_d  = samp_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    vote    = maj3(samp_q[0], samp_q[1], rx_s);
    s_inc   = (s_q == S_LAST) ? '0 : s_q + 1'b1;

    // Clear first so that a set event later in this block wins.
    if (rdy_clr) begin
      rdy_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end

    if (rxclk_en) begin
      if (s_q == S_V0) samp_d[0] = rx_s;
      if (s_q == S_V1) samp_d[1] = rx_s;

      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_d     = SW'(1);
          end
        end
        START: begin
          s_d = s_inc;
          if (s_q == S_V2 && vote) begin
            state_d = IDLE;
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          s_d = s_inc;
          if (s_q == S_V2) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (s_q == S_LAST) begin
            if (bit_q == B_LAST) state_d = STOP;
            else                 bit_d   = bit_q + 1'b1;
          end
        end
        STOP: begin
          s_d = s_inc;
          // Return to IDLE at the vote so back-to-back frames resync on the next start edge.
          if (s_q == S_V2) begin
            state_d = IDLE;
            s_d     = '0;
            if (vote) begin
              data_d = shreg_q;
              rdy_d  = 1'b1;
              if (rdy_q && !rdy_clr) ov_d = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames driven tick-aligned with a 1-in-4 sample enable.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rxclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, busy;
  logic       tick_on = 1'b1;
  int         checks = 0;
  int         errors = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk_50m = ~clk_50m;

  // Sample-enable generator: one tick every 4 clocks, gateable by tick_on.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk_50m);
      #1;
      cnt = (cnt + 1) % 4;
      rxclk_en = tick_on && (cnt == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk_50m);
      n++;
    end while (!rxclk_en && n < 1000);
    if (!rxclk_en) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles, required 1 tick", n);
    end
    #2;
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) wait_tick();
  endtask

  // Start, 8 data bits LSB first, then stop level v held for stop_ticks ticks.
  // gbit >= 0 inverts sample 8 of that data bit for one tick.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_ticks, input int gbit);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        send_bit(b[i], 8);
        send_bit(~b[i], 1);
        send_bit(b[i], 7);
      end else begin
        send_bit(b[i], 16);
      end
    end
    send_bit(stop_v, stop_ticks);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(posedge clk_50m);
    #2;
    rdy_clr = 1'b0;
    wait_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    #2;
    rst = 1'b0;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected %h", data, 8'h00); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    wait_tick();
    send_bit(1'b1, 4);
  endtask

  task automatic test_good_byte();
    send_frame(8'hA5, 1'b1, 9, -1);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL good_rdy_early: got %b expected 0", rdy); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_stop: got %b expected 1", busy); end
    send_bit(1'b1, 1);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL good_rdy: got %b expected 1", rdy); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected %h", data, 8'hA5); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL good_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_idle: got %b expected 0", busy); end
    send_bit(1'b1, 6);
    pulse_clr();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL good_rdy_clr: got %b expected 0", rdy); end
  endtask

  task automatic test_false_start();
    send_bit(1'b0, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    send_bit(1'b1, 6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_prevote: got %b expected 1", busy); end
    send_bit(1'b1, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b expected 0", busy); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b expected 0", rdy); end
    send_bit(1'b1, 20);
    checks++; if (rdy !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL glitch_quiet: got rdy=%b fe=%b expected 0 0", rdy, frame_err); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 10, -1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ferr_rdy: got %b expected 0", rdy); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_hold: got %h expected %h", data, 8'hA5); end
    send_bit(1'b1, 16);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b expected 0", frame_err); end
  endtask

  task automatic test_noise();
    send_frame(8'h3C, 1'b1, 16, 3);
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL noise_data: got %h expected %h", data, 8'h3C); end
    checks++; if (rdy !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL noise_flags: got rdy=%b fe=%b expected 1 0", rdy, frame_err); end
    pulse_clr();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 16, -1);
    send_frame(8'h22, 1'b1, 16, -1);
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h expected %h", data, 8'h22); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ovr_rdy: got %b expected 1", rdy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    pulse_clr();
    checks++; if (overrun !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL ovr_clr: got ovr=%b rdy=%b expected 0 0", overrun, rdy); end
  endtask

  task automatic test_overrun_clr();
    send_frame(8'h11, 1'b1, 16, -1);
    checks++; if (rdy !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL ovc_first: got rdy=%b data=%h expected 1 11", rdy, data); end
    send_frame(8'h22, 1'b1, 9, -1);
    // The vote tick is the fourth edge from here.
    repeat (3) @(posedge clk_50m);
    #2;
    rdy_clr = 1'b1;
    @(posedge clk_50m);
    #2;
    rdy_clr = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ovc_rdy: got %b expected 1", rdy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovc_overrun: got %b expected 0", overrun); end
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL ovc_data: got %h expected %h", data, 8'h22); end
    send_bit(1'b1, 6);
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstm_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk_50m);
    #2;
    rst = 1'b0;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstm_data: got %h expected %h", data, 8'h00); end
    checks++; if (rdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstm_rdy_busy: got rdy=%b busy=%b expected 0 0", rdy, busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstm_flags: got fe=%b ovr=%b expected 0 0", frame_err, overrun); end
    wait_tick();
    send_bit(1'b1, 16);
    send_frame(8'h5A, 1'b1, 16, -1);
    checks++; if (data !== 8'h5A || rdy !== 1'b1) begin errors++; $display("FAIL rstm_next: got data=%h rdy=%b expected 5a 1", data, rdy); end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [4];
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h55; vec[3] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      send_frame(vec[k], 1'b1, 10, -1);
      checks++;
      if (data !== vec[k] || rdy !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame%0d: got data=%h rdy=%b fe=%b ovr=%b expected %h 1 0 0", k, data, rdy, frame_err, overrun, vec[k]);
      end
      rdy_clr = 1'b1;
      send_bit(1'b1, 6);
      rdy_clr = 1'b0;
    end
  endtask

  task automatic test_tick_gating();
    logic [7:0] b;
    b = 8'h96;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(b[i], 16);
    send_bit(b[3], 5);
    tick_on = 1'b0;
    repeat (100) @(posedge clk_50m);
    #2;
    checks++; if (busy !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL gate_frozen: got busy=%b rdy=%b expected 1 0", busy, rdy); end
    tick_on = 1'b1;
    send_bit(b[3], 11);
    for (int i = 4; i < 8; i++) send_bit(b[i], 16);
    send_bit(1'b1, 9);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL gate_rdy_early: got %b expected 0", rdy); end
    send_bit(1'b1, 1);
    checks++; if (rdy !== 1'b1 || data !== 8'h96) begin errors++; $display("FAIL gate_data: got rdy=%b data=%h expected 1 96", rdy, data); end
    send_bit(1'b1, 6);
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_false_start();
    test_frame_err();
    test_noise();
    test_overrun();
    test_overrun_clr();
    test_reset_midframe();
    test_back_to_back();
    test_tick_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampled UART receiver for 8N1 frames. Consumes the 16x sample-enable pulse from the baud rate generator (`rxclk_en`) on the `clk_50m` domain. It synchronizes the asynchronous serial line, majority-votes each bit at mid-bit, and presents received bytes through a ready/clear handshake with sticky error flags. It is the receive-side counterpart of the baud generator's `txclk_en` consumer path.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; 5..8 legal.
- `OVERSAMPLE`, 16: `rxclk_en` ticks per bit; must match the generator; ≥ 8.
- `clk_50m`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `rxclk_en`  in  1: one-cycle sample enable, `OVERSAMPLE`× baud.
- `rx`  in  1: asynchronous serial line, idle high.
- `rdy_clr`  in  1: one-cycle pulse; consumer has taken `data`.
- `data`  out  `DATA_BITS`: last good byte; reset 0.
- `rdy`  out  1: `data` valid, held until cleared; reset 0.
- `frame_err`  out  1: sticky, stop bit sampled low; reset 0.
- `overrun`  out  1: sticky, new byte landed while `rdy`=1; reset 0.
- `busy`  out  1: state ≠ IDLE; reset 0.

## Operation
- **Synchronizer.** `rx` passes through 2 flops, both reset to 1, to give `rx_s`. All logic uses `rx_s`.
- **Sample counter.** `s` is `$clog2(OVERSAMPLE)` bits wide. It advances only on cycles with `rxclk_en`=1 and wraps `OVERSAMPLE-1` → 0. No state or counter changes on cycles without a tick.
- **Voting.** Let M = `OVERSAMPLE/2`. Samples at s = M-1, M, M+1 are captured. At the s = M+1 tick, the bit value is the majority of the three (with the current sample included).
- **IDLE.** On a tick with `rx_s`=0, go to START with s=1; that tick counts as sample 0.
- **START.**
  - At the vote tick, a majority of 1 is a false start: go to IDLE and clear s.
  - At s = `OVERSAMPLE-1`, go to DATA with s=0 and bit index=0.
- **DATA.**
  - At the vote tick, shift the voted bit into the MSB of the shift register (right shift, so LSB-first bits land correctly).
  - At s = `OVERSAMPLE-1`, increment the bit index. After bit `DATA_BITS-1`, go to STOP.
- **STOP.** At the vote tick, go to IDLE immediately; the rest of the stop bit is not waited out.
  - **Vote = 1:** `data` ← shift register and `rdy` ← 1.
    - If `rdy` was already 1 and `rdy_clr` is not asserted this cycle, `overrun` ← 1.
    - `data` is overwritten regardless.
  - **Vote = 0:** `frame_err` ← 1. `data` and `rdy` are unchanged.
- **rdy_clr.** Clears `rdy`, `frame_err` and `overrun`. If a set event occurs in the same cycle, the set wins for that flag. A simultaneous good byte with `rdy_clr` raises no overrun.
- **Break (line held low).** Produces a new START every frame time and re-asserts `frame_err` each frame. No lockup.
- **Reset.** `rst` at any point, including mid-frame, returns the FSM to IDLE, clears s, the bit index and the shift register, and returns all outputs and sync flops to their reset values on the next edge.

## Timing
- 2 `clk_50m` cycles of synchronizer latency, plus up to 1 tick of start-detect quantization.
- `rdy` rises on the clock edge that registers the stop-bit vote tick. With default parameters that is M+1 = 9 ticks into the stop bit, i.e. about 9.5 bit-times after the falling edge of the start bit.
- `busy` is high from the START-entry edge through the STOP vote edge.
- Outputs are registered; there is no combinational path from input to output.

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_rx_state_t` {IDLE, START, DATA, STOP};
  - `UART_OVERSAMPLE` = 16;
  - `UART_DATA_BITS` = 8.
- **Sub-module `uart_rx_sync`:** 2-flop synchronizer, parameterized reset value (1). It is reused by any future async-input block.
- Vote logic, counters and FSM stay in `uart_rx`.

## Test plan
- **Good byte.** 0xA5 sent 8N1 at an exact 16-tick bit period → `rdy`=1, `data`=0xA5, `frame_err`=0 and `overrun`=0. `rdy_clr` → `rdy`=0.
- **False start and noise rejection.**
  - 3-tick low glitch on an idle line → START entered, vote=1, back to IDLE; `rdy` stays 0 and `busy` drops.
  - 1-tick inverted glitch at sample 8 of data bit 3 of 0x3C → `data`=0x3C.
- **Framing error.** 0x3C with the stop bit driven low → `frame_err`=1, `rdy`=0, `data` still holds its previous value. `rdy_clr` clears `frame_err`.
- **Overrun and simultaneous clear.**
  - 0x11 then 0x22 with no `rdy_clr` → `data`=0x22, `rdy`=1, `overrun`=1.
  - Repeat with `rdy_clr` pulsed on the exact cycle the second byte lands → `rdy`=1, `overrun`=0.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 of 0xFF → all outputs 0 on the next edge, FSM in IDLE. A following 0x5A is received correctly.
- **Back-to-back and tick gating.**
  - 4 frames (0x00, 0xFF, 0x55, 0x80) with no idle gap → all received, `frame_err`=0.
  - Hold `rxclk_en`=0 mid-frame for 100 cycles → FSM and counters frozen.
